// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared ALU instead of owning
// a multiplier: each iteration sequences ADD, SLL and SRL through the ALU ports.
module alu_mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] multiplicand_i,
    input  logic [WIDTH-1:0] multiplier_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o,
    output logic [3:0]       alu_operation_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_result_i,
    output logic [2:0]       state_dbg_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b0110;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_SLL  = 3'd2,
        S_SRL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q,  mplr_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Request/completion protocol: start_i is a request that is only taken
    // while IDLE (a cycle with start_i=1 in IDLE is the acceptance); there is
    // no back-pressure and no queueing, so any start_i seen while busy_o=1 is
    // dropped. done_o pulses for one cycle and product_o stays valid until
    // the next accepted request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        mcand_d         = mcand_q;
        mplr_d          = mplr_q;
        acc_d           = acc_q;
        cnt_d           = cnt_q;
        alu_operation_o = OP_ADD;
        alu_a_o         = '0;
        alu_b_o         = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mcand_d = multiplicand_i;
                    mplr_d  = multiplier_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (multiplier_i == '0) ? S_DONE : S_ADD;
                end
            end
            S_ADD: begin
                alu_operation_o = OP_ADD;
                alu_a_o         = acc_q;
                alu_b_o         = mplr_q[0] ? mcand_q : '0;
                acc_d           = alu_result_i;
                state_d         = S_SLL;
            end
            S_SLL: begin
                alu_operation_o = OP_SLL;
                alu_a_o         = mcand_q;
                alu_b_o         = WIDTH'(1);
                mcand_d         = alu_result_i;
                state_d         = S_SRL;
            end
            S_SRL: begin
                alu_operation_o = OP_SRL;
                alu_a_o         = mplr_q;
                alu_b_o         = WIDTH'(1);
                mplr_d          = alu_result_i;
                // Stop early once no set multiplier bits remain.
                if ((alu_result_i == '0) || (cnt_q == CNT_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign product_o   = acc_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a behavioural ALU, vector table,
// hand-written corner sequences and a random run checked against plain arithmetic.
module tb_alu_mul_sequencer;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          start_i;
  logic [W-1:0]  multiplicand_i;
  logic [W-1:0]  multiplier_i;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  product_o;
  logic [3:0]    alu_operation_o;
  logic [W-1:0]  alu_a_o;
  logic [W-1:0]  alu_b_o;
  logic [W-1:0]  alu_result_i;
  logic [2:0]    state_dbg_o;

  int checks;
  int failures;
  int cyc;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_p;
    int           exp_lat;
  } vec_t;

  vec_t vecs[8];

  alu_mul_sequencer #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .multiplicand_i  (multiplicand_i),
    .multiplier_i    (multiplier_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .product_o       (product_o),
    .alu_operation_o (alu_operation_o),
    .alu_a_o         (alu_a_o),
    .alu_b_o         (alu_b_o),
    .alu_result_i    (alu_result_i),
    .state_dbg_o     (state_dbg_o)
  );

  // clock / behavioural ALU
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_operation_o)
      4'b0000: alu_result_i = alu_a_o + alu_b_o;
      4'b0111: alu_result_i = alu_a_o << alu_b_o[4:0];
      4'b0110: alu_result_i = alu_a_o >> alu_b_o[4:0];
      default: alu_result_i = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Drive inputs for the current cycle, then move to the middle of the next one.
  task automatic tick(input logic st, input logic [W-1:0] a, input logic [W-1:0] b);
    start_i        = st;
    multiplicand_i = a;
    multiplier_i   = b;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Reference model: plain arithmetic from the multiply rules.
  function automatic int ref_lat(input logic [W-1:0] b);
    int k;
    k = 0;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
    return 3 * k + 1;
  endfunction

  function automatic logic [W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return full[W-1:0];
  endfunction

  // Full multiply with per-cycle ALU checks; cycle numbers are relative to acceptance.
  task automatic run_check(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_p, input int exp_lat, input string nm);
    int lat;
    int it;
    int ph;
    logic [W-1:0] mask;
    lat = -1;
    cyc = 0;
    tick(1'b1, a, b);
    for (int c = 1; c <= 110 && lat < 0; c++) begin
      if (c < exp_lat) begin
        it = (c - 1) / 3;
        ph = (c - 1) % 3;
        mask = (it == 0) ? '0 : ((32'h1 << it) - 32'h1);
        case (ph)
          0: begin
            chk({nm, "_op_add"}, alu_operation_o, 4'b0000);
            chk({nm, "_add_a"}, alu_a_o, a * (b & mask));
            chk({nm, "_add_b"}, alu_b_o, b[it] ? (a << it) : '0);
          end
          1: begin
            chk({nm, "_op_sll"}, alu_operation_o, 4'b0111);
            chk({nm, "_sll_a"}, alu_a_o, a << it);
            chk({nm, "_sll_b"}, alu_b_o, 32'd1);
          end
          default: begin
            chk({nm, "_op_srl"}, alu_operation_o, 4'b0110);
            chk({nm, "_srl_a"}, alu_a_o, b >> it);
            chk({nm, "_srl_b"}, alu_b_o, 32'd1);
          end
        endcase
      end else begin
        chk({nm, "_op_idle"}, alu_operation_o, 4'b0000);
        chk({nm, "_a_idle"}, alu_a_o, '0);
        chk({nm, "_b_idle"}, alu_b_o, '0);
      end
      chk({nm, "_busy"}, busy_o, 1'b1);
      if (done_o) begin
        lat = c;
        chk({nm, "_product"}, product_o, exp_p);
        chk({nm, "_latency"}, lat, exp_lat);
      end else begin
        tick(1'b0, $urandom, $urandom);
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done_by_cycle_%0d", nm, exp_lat);
    end
    tick(1'b0, '0, '0);
    chk({nm, "_done_single"}, done_o, 1'b0);
    chk({nm, "_busy_after"}, busy_o, 1'b0);
    chk({nm, "_product_hold"}, product_o, exp_p);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    reset          = 1'b0;
    start_i        = 1'b0;
    multiplicand_i = '0;
    multiplier_i   = '0;

    vecs[0] = '{a: 32'd6,          b: 32'd7,          exp_p: 32'd42,         exp_lat: 10};
    vecs[1] = '{a: 32'd5,          b: 32'd0,          exp_p: 32'd0,          exp_lat: 1};
    vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  exp_p: 32'h0000_0001,  exp_lat: 97};
    vecs[3] = '{a: 32'd3,          b: 32'd3,          exp_p: 32'd9,          exp_lat: 7};
    vecs[4] = '{a: 32'd1,          b: 32'd1,          exp_p: 32'd1,          exp_lat: 4};
    vecs[5] = '{a: 32'd3,          b: 32'h8000_0000,  exp_p: 32'h8000_0000,  exp_lat: 97};
    vecs[6] = '{a: 32'd0,          b: 32'd5,          exp_p: 32'd0,          exp_lat: 10};
    vecs[7] = '{a: 32'h0001_0000,  b: 32'h0001_0001,  exp_p: 32'h0001_0000,  exp_lat: 52};

    @(negedge clk);
    tick(1'b0, '0, '0);
    tick(1'b0, '0, '0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_done", done_o, 1'b0);
    chk("reset_product", product_o, '0);
    chk("reset_op", alu_operation_o, 4'b0000);
    reset = 1'b1;
    tick(1'b0, '0, '0);
    chk("idle_busy", busy_o, 1'b0);

    foreach (vecs[i]) run_check(vecs[i].a, vecs[i].b, vecs[i].exp_p, vecs[i].exp_lat, $sformatf("vec%0d", i));

    // Starts while busy and in DONE are dropped; the next IDLE start is taken.
    cyc = 0;
    tick(1'b1, 32'd6, 32'd7);
    while (cyc < 18) begin
      if (cyc == 10) begin
        chk("ign_done10", done_o, 1'b1);
        chk("ign_prod10", product_o, 32'd42);
      end else if (cyc == 11) begin
        chk("ign_busy11", busy_o, 1'b0);
        chk("ign_prod11", product_o, 32'd42);
      end else begin
        chk("ign_nodone", done_o, 1'b0);
        chk("ign_busy", busy_o, 1'b1);
      end
      tick((cyc == 3) || (cyc == 10) || (cyc == 11), 32'd2, 32'd2);
    end
    chk("ign_done18", done_o, 1'b1);
    chk("ign_prod18", product_o, 32'd4);
    tick(1'b0, '0, '0);
    chk("ign_idle19", busy_o, 1'b0);

    // Reset mid-operation abandons the multiply without a done pulse.
    cyc = 0;
    tick(1'b1, 32'h1234, 32'h100);
    while (cyc < 5) tick(1'b0, '0, '0);
    chk("rst_busy_before", busy_o, 1'b1);
    reset = 1'b0;
    tick(1'b0, '0, '0);
    reset = 1'b1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_product", product_o, '0);
    chk("rst_done", done_o, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, '0, '0);
      chk("rst_nodone", done_o, 1'b0);
    end
    run_check(32'd3, 32'd3, 32'd9, 7, "post_rst");

    // Random operands; multiplier length varied to cover many latencies.
    for (int n = 0; n < 500; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 19) == 0) rb = '0;
      run_check(ra, rb, ref_prod(ra, rb), ref_lat(rb), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle unsigned multiplier (low WIDTH bits of product) with no multiplier hardware of its own.
- It computes by sequencing the existing ALU through a shift-and-add loop: add, then shift-left, then shift-right, repeated.
- It sits beside the ALU. A datapath mux (outside this block) hands ALU inputs and operation to this block while busy_o=1.
- It uses only existing ALU operation codes: 0000 ADD, 0111 SLL, 0110 SRL.

Parameters:
- WIDTH, 32, operand/result width; also the maximum iteration count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous active-low reset.
- start_i  input  1  request a multiply; sampled only in IDLE.
- multiplicand_i  input  WIDTH  operand A; captured with start_i.
- multiplier_i  input  WIDTH  operand B; captured with start_i.
- busy_o  output  1  high from the cycle after start acceptance through the DONE cycle inclusive.
- done_o  output  1  one-cycle pulse, product_o valid.
- product_o  output  WIDTH  accumulator; (A*B) mod 2^WIDTH once done_o fires; held until the next accepted start.
- alu_operation_o  output  4  operation code driven to the ALU.
- alu_a_o  output  WIDTH  ALU operand A.
- alu_b_o  output  WIDTH  ALU operand B.
- alu_result_i  input  WIDTH  combinational ALU result for the current cycle's operation.

Behaviour:
Registers:
- mcand_q, mplr_q, acc_q (drives product_o).
- cnt_q, width clog2(WIDTH).
- state_q: IDLE, ADD, SLL, SRL, DONE.

Reset (reset==0 at a clock edge):
- state=IDLE; acc/mcand/mplr/cnt = 0.
- busy_o=0, done_o=0, product_o=0.
- Applies mid-operation: the in-flight multiply is abandoned and no done_o is issued.

ALU drive per state:
- IDLE, DONE: op=0000, a=0, b=0.
- ADD: op=0000, a=acc_q, b=(mplr_q[0] ? mcand_q : 0); acc_q<=alu_result_i.
- SLL: op=0111, a=mcand_q, b=1; mcand_q<=alu_result_i.
- SRL: op=0110, a=mplr_q, b=1; mplr_q<=alu_result_i.

Transitions:
- IDLE, start_i=1:
  - capture mcand_q<=multiplicand_i, mplr_q<=multiplier_i; acc_q<=0, cnt_q<=0.
  - multiplier_i==0 -> DONE; else -> ADD.
- IDLE, start_i=0: stay; all registers hold.
- ADD -> SLL -> SRL (unconditional).
- SRL:
  - if alu_result_i==0 or cnt_q==WIDTH-1 -> DONE;
  - else cnt_q<=cnt_q+1, -> ADD.
- DONE: done_o=1 for exactly this cycle -> IDLE.
  - start_i in DONE is ignored; earliest next acceptance is the following IDLE cycle.
  - start_i while busy is ignored (no queueing); operand inputs are don't-care after capture.

Timing and arithmetic:
- Latency: with the start sampled at edge 0, k = index of the multiplier's highest set bit + 1.
  - done_o is high in cycle 3k+1.
  - Multiplier 0 gives done_o in cycle 1 with product 0.
- All arithmetic wraps mod 2^WIDTH; carries out of bit WIDTH-1 are discarded; the operation is unsigned only.
- busy_o = (state != IDLE), registered-state decode. done_o = (state == DONE).

Test Plan:
- Bench provides a behavioural ALU (0000 add, 0111 sll, 0110 srl, mod 2^32).
- A=6, B=7, start in cycle 0:
  - op sequence 0000,0111,0110 repeated 3 times;
  - done_o high only in cycle 10, product_o=42, busy_o high cycles 1-10.
- A=5, B=0: done_o in cycle 1, product_o=0, no ADD/SLL/SRL state entered, ALU lines stay 0.
- A=0xFFFFFFFF, B=0xFFFFFFFF: 32 iterations, done_o in cycle 97, product_o=0x00000001.
- Start 6*7, then pulse start_i with A=2, B=2 in cycles 3 and 10:
  - both ignored; product_o=42 at cycle 10;
  - a new start in cycle 11 is accepted, product_o=4 at cycle 18 (B=2 gives k=2, done cycle 7 after acceptance).
- Start 0x1234*0x100, assert reset low in cycle 5 for one edge:
  - next cycle busy_o=0, product_o=0, no done_o;
  - a following 3*3 gives 9.
- Random 500 unsigned pairs:
  - product_o == (A*B) mod 2^32 at each done_o pulse;
  - latency == 3k+1;
  - exactly one done_o per accepted start.
